// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache-to-DDR2 memory controller slice.
package cache_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used as the read-data timeout; done flags count == MAX.
module sat_counter #(
    parameter int MAX = 1023,
    parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_n;

    always_comb begin
        count_n = count;
        if (clear) begin
            count_n = '0;
        end else if (enable && (count != W'(MAX))) begin
            count_n = count + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else begin
            count <= count_n;
        end
    end

    assign done = (count == W'(MAX));

endmodule

// File: rtl/cache_mem_ctrl.sv
// Single-outstanding bridge from cache miss / write-through requests to a DDR2
// controller command port, with a bounded wait for read data.
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int DATA_W  = cache_pkg::DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_en,
    input  logic              mem_rdy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state;
    state_t        state_n;
    req_t          req_q;
    logic [CW-1:0] cnt_q;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_done;
    logic          timed_out;

    assign cnt_clr = (state == ISSUE) && mem_rdy && !req_q.write;
    assign cnt_en  = (state == WAIT_RD) && !mem_rvalid;

    sat_counter #(
        .MAX (TIMEOUT),
        .W   (CW)
    ) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .count  (cnt_q),
        .done   (cnt_done)
    );

    // Times out on the cycle whose increment makes the count reach TIMEOUT,
    // so WAIT_RD lasts exactly TIMEOUT cycles; a data beat that cycle still wins.
    assign timed_out = cnt_done || (cnt_en && (cnt_q == CW'(TIMEOUT - 1)));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = ISSUE;
            ISSUE:   if (mem_rdy) state_n = req_q.write ? RESP : WAIT_RD;
            WAIT_RD: if (mem_rvalid || timed_out) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            req_q      <= '0;
            req_ready  <= 1'b0;
            mem_en     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == IDLE);
            mem_en     <= (state_n == ISSUE);
            resp_valid <= (state_n == RESP);
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= '{write: req_write,
                                   addr:  req_addr & ~ADDR_W'(3),
                                   wdata: req_wdata};
                    end
                end
                ISSUE: begin
                    if (mem_rdy) begin
                        resp_data <= '0;
                        resp_err  <= 1'b0;
                    end
                end
                WAIT_RD: begin
                    if (mem_rvalid) begin
                        resp_data <= mem_rdata;
                        resp_err  <= 1'b0;
                    end else if (timed_out) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    resp_data <= '0;
                    resp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = req_q.write;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench: stimulus queues expected commands/responses, a negedge monitor checks them.
module tb_cache_mem_ctrl;

    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          mem_en;
    logic          mem_rdy = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    cache_mem_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_rdy    (mem_rdy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } resp_exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            len;
    } cmd_exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [AW-1:0] ea;
        logic [DW-1:0] wd;
        int            rdy_d;
        int            rv_d;
        logic [DW-1:0] rd;
        bit            give_rv;
        bit            exp_resp;
        int            elen;
        logic [DW-1:0] edata;
        logic          eerr;
        int            elat;
    } vec_t;

    resp_exp_t resp_q[$];
    cmd_exp_t  cmd_q[$];
    int tests = 0;
    int fails = 0;

    int            ncyc = 0;
    int            acc_cyc = 0;
    int            en_run = 0;
    logic          prev_stall = 1'b0;
    logic          prev_acc = 1'b0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;
    cmd_exp_t      mc;
    resp_exp_t     mr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (!rstn) begin
            en_run     = 0;
            prev_stall = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_en", mem_en, 1);
                chk("hold_we", mem_we, prev_we);
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_wdata", mem_wdata, prev_wdata);
            end
            if (prev_acc) chk("en_drop_after_accept", mem_en, 0);
            if (mem_en || resp_valid) chk("ready_low_busy", req_ready, 0);
            en_run     = mem_en ? en_run + 1 : 0;
            prev_stall = mem_en && !mem_rdy;
            prev_acc   = mem_en && mem_rdy;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            if (mem_en && mem_rdy) begin
                if (cmd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cmd_unexpected: got acceptance addr 0x%0h, expected none", mem_addr);
                end else begin
                    mc = cmd_q.pop_front();
                    chk("cmd_we", mem_we, mc.we);
                    chk("cmd_addr", mem_addr, mc.addr);
                    chk("cmd_wdata", mem_wdata, mc.wdata);
                    chk("cmd_en_cycles", en_run, mc.len);
                end
                acc_cyc = ncyc;
                en_run  = 0;
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_unexpected: got resp data 0x%0h err %0b, expected none", resp_data, resp_err);
                end else begin
                    mr = resp_q.pop_front();
                    chk("resp_data", resp_data, mr.data);
                    chk("resp_err", resp_err, mr.err);
                    chk("resp_latency", ncyc - acc_cyc, mr.lat);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] ea,
                                input logic [DW-1:0] wd, input int rdy_d, input int rv_d,
                                input logic [DW-1:0] rd, input bit give_rv, input bit exp_resp,
                                input int elen, input logic [DW-1:0] edata, input logic eerr,
                                input int elat);
        vec_t v;
        v = '{wr: wr, a: a, ea: ea, wd: wd, rdy_d: rdy_d, rv_d: rv_d, rd: rd, give_rv: give_rv,
              exp_resp: exp_resp, elen: elen, edata: edata, eerr: eerr, elat: elat};
        return v;
    endfunction

    task automatic send(input vec_t v, input bit hold, input bit chk_rdy);
        bit seen;
        if (chk_rdy) chk("ready_idle", req_ready, 1);
        cmd_q.push_back('{we: v.wr, addr: v.ea, wdata: v.wd, len: v.elen});
        if (v.exp_resp) resp_q.push_back('{data: v.edata, err: v.eerr, lat: v.elat});
        req_write = v.wr;
        req_addr  = v.a;
        req_wdata = v.wd;
        req_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL mem_en_wait: got no mem_en in 20 cycles, expected mem_en=1");
            req_valid = 1'b0;
            return;
        end
        if (!hold) req_valid = 1'b0;
        step(v.rdy_d);
        mem_rdy = 1'b1;
        step(1);
        mem_rdy = 1'b0;
        if (!v.wr && v.give_rv) begin
            step(v.rv_d);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rd;
            step(1);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check_reset_outputs();
        rstn = 1'b1;
        step(1);
        chk("ready_after_init_rst", req_ready, 1);

        // read with immediate accept, data 3 cycles later
        send(mk(1'b0, 27'h0001237, 27'h0001234, 32'h0, 0, 3, 32'hDEADBEEF, 1, 1,
                1, 32'hDEADBEEF, 1'b0, 5), 1'b0, 1'b1);
        step(3);
        // write stalled 5 cycles by mem_rdy
        send(mk(1'b1, 27'h0000010, 27'h0000010, 32'hCAFEF00D, 5, 0, 32'h0, 0, 1,
                6, 32'h0, 1'b0, 1), 1'b0, 1'b1);
        step(3);
        // read timeout, no data beat
        send(mk(1'b0, 27'h7FFFFFF, 27'h7FFFFFC, 32'h0, 2, 0, 32'h0, 0, 1,
                3, 32'h0, 1'b1, 9), 1'b0, 1'b1);
        step(12);
        // data beat on the very cycle the counter reaches TIMEOUT
        send(mk(1'b0, 27'h0000101, 27'h0000100, 32'h0, 0, 7, 32'h12345678, 1, 1,
                1, 32'h12345678, 1'b0, 9), 1'b0, 1'b1);
        step(3);
        // data beat one cycle too late: timeout, beat ignored
        send(mk(1'b0, 27'h0000202, 27'h0000200, 32'h0, 1, 8, 32'h55AA55AA, 1, 1,
                2, 32'h0, 1'b1, 9), 1'b0, 1'b1);
        step(3);
        // data beat one cycle before the limit
        send(mk(1'b0, 27'h0000306, 27'h0000304, 32'h0, 0, 6, 32'hA5A5A5A5, 1, 1,
                1, 32'hA5A5A5A5, 1'b0, 8), 1'b0, 1'b1);
        step(3);
        send(mk(1'b1, 27'h7FFFFFE, 27'h7FFFFFC, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 1,
                1, 32'h0, 1'b0, 1), 1'b0, 1'b1);
        step(3);

        // stray data beat while idle
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAADF00D;
        step(1);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        step(3);

        // reset during WAIT_RD, then a late beat
        send(mk(1'b0, 27'h0000042, 27'h0000040, 32'h0, 0, 0, 32'h0, 0, 0,
                1, 32'h0, 1'b0, 0), 1'b0, 1'b1);
        step(3);
        rstn = 1'b0;
        step(1);
        check_reset_outputs();
        step(1);
        rstn       = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD0BAD;
        step(1);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        chk("ready_after_mid_rst", req_ready, 1);
        step(14);

        // back-to-back with req_valid held high
        send(mk(1'b1, 27'h0000AAA, 27'h0000AA8, 32'h11112222, 1, 0, 32'h0, 0, 1,
                2, 32'h0, 1'b0, 1), 1'b1, 1'b1);
        send(mk(1'b0, 27'h0000555, 27'h0000554, 32'h0, 0, 0, 32'h0F0F0F0F, 1, 1,
                1, 32'h0F0F0F0F, 1'b0, 2), 1'b1, 1'b0);
        send(mk(1'b1, 27'h0000003, 27'h0000000, 32'h33334444, 0, 0, 32'h0, 0, 1,
                1, 32'h0, 1'b0, 1), 1'b0, 1'b0);
        step(15);

        chk("resp_queue_drained", resp_q.size(), 0);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
